// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared constants and types for the instruction-fetch stage.
//   NOP_INST          : instruction word presented in empty IF/ID slots
//   DEFAULT_RESET_PC  : default PC after reset
//   DEFAULT_PC_STEP   : default byte step between sequential fetches
//   fetch_state_t     : single-outstanding fetch FSM states
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// ---------------------------------------------------------------------------
// if_prefetch_fifo
// Two-entry FIFO holding fetched {inst, pc} pairs between the memory
// response and the IF/ID output register. Only built when
// IF_PREFETCH_BUF_EN is defined.
//   clk, rst_n   : clock, synchronous active-low reset
//   i_flush      : drop all entries (redirect)
//   i_push/i_data: write one {inst, pc} entry, ignored when full
//   i_pop        : remove the head entry, ignored when empty
//   o_data       : head entry
//   o_full/o_empty/o_count : occupancy status
// ---------------------------------------------------------------------------
`ifdef IF_PREFETCH_BUF_EN
module if_prefetch_fifo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_push,
    input  logic [63:0] i_data,
    input  logic        i_pop,
    output logic [63:0] o_data,
    output logic        o_full,
    output logic        o_empty,
    output logic [1:0]  o_count
);
    logic [63:0] r_mem [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;
    logic        w_push_ok;
    logic        w_pop_ok;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop_ok) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
        end
    end
endmodule
`endif

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: owns the PC, fetches one word at a time over a
// req/gnt/rvalid handshake and drives the IF/ID register (IF_inst/IF_pc/
// IF_valid). Redirects from EX squash in-flight fetches; empty slots carry
// NOP_INST.
// Build option: IF_PREFETCH_BUF_EN adds a 2-entry prefetch FIFO and allows
// two outstanding requests (one instruction per cycle on zero-wait memory).
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   is_stall                    : downstream not consuming this edge
//   redirect_valid, redirect_pc : taken branch/jump target from EX
//   imem_req, imem_addr         : fetch request / word address
//   imem_gnt, imem_rvalid, imem_rdata : memory accept / response
//   IF_inst, IF_pc, IF_valid    : IF/ID register contents
//
// Fetch FSM (default build):
//   state  | meaning
//   S_REQ  | request pc when the output register can take the result
//   S_WAIT | one request outstanding; squash drops its response
// ---------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_pc,
    output logic        IF_valid
);
    logic [31:0] r_pc;
    logic [31:0] r_if_inst;
    logic [31:0] r_if_pc;
    logic        r_if_valid;
    logic        w_imem_req;
    logic        w_consume;
    logic        w_out_free;

    assign w_consume  = r_if_valid & ~is_stall;
    assign w_out_free = ~r_if_valid | w_consume;

    assign imem_req   = w_imem_req;
    assign imem_addr  = r_pc;
    assign IF_inst    = r_if_inst;
    assign IF_pc      = r_if_pc;
    assign IF_valid   = r_if_valid;

`ifdef IF_PREFETCH_BUF_EN
    logic [1:0]  r_outst;
    logic [1:0]  r_sq_cnt;
    logic [31:0] r_rsp_pc;
    logic [1:0]  w_fifo_count;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [63:0] w_fifo_head;
    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic        w_rsp_any;
    logic [1:0]  w_occ_eff;
    logic [2:0]  w_inflight;
    logic [1:0]  w_outst_nxt;

    if_prefetch_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  ({imem_rdata, r_rsp_pc}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Occupancy counts the slot freed by this edge's pop so the FIFO can
    // stream one word per cycle; pop does not depend on gnt, so no loop.
    always_comb begin
        w_pop       = ~w_fifo_empty & w_out_free & ~redirect_valid;
        w_occ_eff   = w_fifo_count - {1'b0, w_pop};
        w_inflight  = {1'b0, w_occ_eff} + {1'b0, r_outst};
        w_imem_req  = rst_n & (w_inflight < 3'd2);
        w_issue     = w_imem_req & imem_gnt;
        // Responses with nothing outstanding are stale (e.g. across reset).
        w_rsp_any   = imem_rvalid & (r_outst != 2'd0);
        w_push      = w_rsp_any & (r_sq_cnt == 2'd0) & ~redirect_valid & ~w_fifo_full;
        w_outst_nxt = r_outst + {1'b0, w_issue} - {1'b0, w_rsp_any};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_outst    <= 2'd0;
            r_sq_cnt   <= 2'd0;
            r_if_inst  <= NOP_INST;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
        end else begin
            r_outst <= w_outst_nxt;
            if (redirect_valid) begin
                r_pc       <= word_align(redirect_pc);
                r_rsp_pc   <= word_align(redirect_pc);
                r_sq_cnt   <= w_outst_nxt;
                r_if_inst  <= NOP_INST;
                r_if_valid <= 1'b0;
            end else begin
                if (w_issue) r_pc <= r_pc + PC_STEP;
                if (w_push)  r_rsp_pc <= r_rsp_pc + PC_STEP;
                if (w_rsp_any && (r_sq_cnt != 2'd0)) r_sq_cnt <= r_sq_cnt - 2'd1;
                if (w_pop) begin
                    r_if_inst  <= w_fifo_head[63:32];
                    r_if_pc    <= w_fifo_head[31:0];
                    r_if_valid <= 1'b1;
                end else if (w_consume) begin
                    r_if_inst  <= NOP_INST;
                    r_if_valid <= 1'b0;
                end
            end
        end
    end
`else
    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_req_pc, w_req_pc_nxt;
    logic [31:0]  w_pc_nxt, w_if_inst_nxt, w_if_pc_nxt;
    logic         r_squash, w_squash_nxt, w_if_valid_nxt;
    logic         w_granted;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_pc_nxt   = r_req_pc;
        w_squash_nxt   = r_squash;
        w_if_inst_nxt  = r_if_inst;
        w_if_pc_nxt    = r_if_pc;
        w_if_valid_nxt = r_if_valid;
        w_imem_req     = 1'b0;
        w_granted      = 1'b0;

        if (w_consume) begin
            w_if_valid_nxt = 1'b0;
            w_if_inst_nxt  = NOP_INST;
        end

        case (r_state)
            S_REQ: begin
                w_imem_req = rst_n & w_out_free;
                w_granted  = w_imem_req & imem_gnt;
                if (w_granted) begin
                    w_req_pc_nxt = r_pc;
                    w_state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                    if (r_squash) begin
                        w_squash_nxt = 1'b0;
                    end else begin
                        w_if_inst_nxt  = imem_rdata;
                        w_if_pc_nxt    = r_req_pc;
                        w_if_valid_nxt = 1'b1;
                        w_pc_nxt       = r_req_pc + PC_STEP;
                    end
                end
            end
            default: w_state_nxt = S_REQ;
        endcase

        // A response landing with the redirect completes the old request, so
        // only a still-pending or just-granted request needs squashing.
        if (redirect_valid) begin
            w_pc_nxt       = word_align(redirect_pc);
            w_if_inst_nxt  = NOP_INST;
            w_if_valid_nxt = 1'b0;
            if (((r_state == S_WAIT) && !imem_rvalid) || w_granted) begin
                w_squash_nxt = 1'b1;
                w_state_nxt  = S_WAIT;
            end else begin
                w_squash_nxt = 1'b0;
                w_state_nxt  = S_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_squash   <= 1'b0;
            r_if_inst  <= NOP_INST;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_pc   <= w_req_pc_nxt;
            r_squash   <= w_squash_nxt;
            r_if_inst  <= w_if_inst_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
        end
    end
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage of the pipelined CPU: owns the PC, issues single-word requests to instruction memory over a req/gnt/rvalid handshake, and drives IF_inst/IF_pc into the IF/ID pipeline register. Honours the hazard unit's is_stall, and redirects from EX on taken branches or jumps, squashing any in-flight fetch. Empty slots present NOP_INST.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment between sequential fetches.

Ports:
clk  in  1  pipeline clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
is_stall  in  1  hazard unit: downstream is not consuming the IF output this edge.
redirect_valid  in  1  EX: branch/jump taken; load redirect_pc.
redirect_pc  in  32  redirect target.
imem_req  out  1  fetch request valid.
imem_addr  out  32  fetch address (word aligned).
imem_gnt  in  1  memory accepted the request this cycle.
imem_rvalid  in  1  read data valid.
imem_rdata  in  32  instruction word.
IF_inst  out  32  instruction to IF/ID register.
IF_pc  out  32  PC of IF_inst.
IF_valid  out  1  IF_inst is a real fetched instruction (0 = bubble).

Behaviour:
- Reset (rst_n=0 at an edge): pc<=RESET_PC, state<=S_REQ, squash<=0, IF_inst<=NOP_INST, IF_pc<=0, IF_valid<=0. imem_req=0 during any cycle with rst_n=0; it is asserted the first cycle after reset. Reset mid-transaction abandons the transaction; a stale rvalid arriving afterwards is ignored (rvalid is only honoured in S_WAIT).
- FSM (one request in flight max):
  S_REQ: imem_req=1, imem_addr=pc. Issue condition: output register empty, or being consumed this edge (IF_valid=1 and is_stall=0). If the condition is false, imem_req=0. On imem_req&imem_gnt: req_pc<=pc, go to S_WAIT.
  S_WAIT: imem_req=0. On imem_rvalid: if squash, drop the data, squash<=0, go to S_REQ. Otherwise load the output register (IF_inst<=imem_rdata, IF_pc<=req_pc, IF_valid<=1), pc<=req_pc+PC_STEP, go to S_REQ.
- Output register consumption: at an edge with is_stall=0 and no new load, IF_valid<=0 and IF_inst<=NOP_INST. With is_stall=1 the output holds unchanged.
- Zero-wait memory (gnt same cycle, rvalid next cycle): one instruction per 2 cycles.
- Redirect has the highest priority and takes effect at that edge:
  - pc<=redirect_pc with bits [1:0] forced to 00.
  - The output register is cleared to a bubble, even if is_stall=1.
  - If a request is in S_WAIT, or is granted this same cycle, squash<=1 and state goes to S_WAIT.
  - In S_REQ without gnt, imem_addr may change to the new pc next cycle. This is the only permitted address change before gnt.
  - An rvalid in the same cycle as a redirect is dropped.
- Outside redirect, imem_addr is held stable while imem_req=1 and gnt=0.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Simultaneous redirect + is_stall: redirect wins. Simultaneous reset + anything: reset wins.

Optional Feature:
Macro: IF_PREFETCH_BUF_EN.
- Defined:
  - Adds a 2-entry prefetch FIFO (inst, pc) between memory response and the output register.
  - Up to 2 requests may be outstanding. A request is issued whenever FIFO occupancy + outstanding < 2.
  - Output loads from the FIFO head, giving 1 instruction/cycle with zero-wait memory.
  - Redirect flushes the FIFO and squashes all outstanding responses, using a squash counter instead of a flag.
  - FIFO full: no issue.
  - FIFO empty with is_stall=0: bubble.
- Undefined: single-outstanding behaviour as above, with no FIFO logic.

Decomposition:
- Shared package/defines: NOP_INST (32'h0000_0013), default RESET_PC, fetch FSM state encodings (S_REQ, S_WAIT).
- Sub-module if_prefetch_fifo (2-entry, 64-bit payload, push/pop/flush, full/empty), instantiated only under IF_PREFETCH_BUF_EN.

Test Plan:
1. Reset, zero-wait memory returning addr as data, is_stall=0 -> imem_addr 0,4,8 on successive requests; IF_pc=0,4,8 with IF_valid=1 every second cycle; bubbles carry 32'h13.
2. Hold is_stall=1 for 3 cycles while IF_pc=4 -> IF_inst/IF_pc unchanged, imem_req=0; after release, the next fetch of addr 8 issues the same cycle.
3. redirect_valid with redirect_pc=32'h100 while in S_WAIT for addr 8 -> response for 8 is dropped, IF_valid=0, next imem_addr=32'h100, then IF_pc=32'h100.
4. redirect_valid + is_stall=1 in the same cycle, redirect_pc=32'h203 -> output cleared, next imem_addr=32'h200.
5. RESET_PC=32'hFFFF_FFFC -> first fetch at FFFF_FFFC, next imem_addr=32'h0.
6. rst_n=0 for one cycle while in S_WAIT, then rvalid arrives -> response ignored, imem_addr=RESET_PC, IF_valid=0; with IF_PREFETCH_BUF_EN, scenario 1 yields IF_valid=1 every cycle.
